// File: rtl/mcse_bus_pkg.sv
// Shared AHB-Lite encodings and boot bus translator state type.
package mcse_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_INCR = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } btu_state_t;

  // AHB HSIZE encoding is log2 of the transfer size in bytes
  function automatic logic [2:0] hsize_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/boot_bus_wdt.sv
// Watchdog counting consecutive HREADY-low cycles within one data phase.
module boot_bus_wdt #(
  parameter int pTIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(pTIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Saturates at the limit so timeout stays asserted until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !timeout) begin
      count <= count + CW'(1);
    end
  end

  assign timeout = (count == CW'(pTIMEOUT_CYCLES));

endmodule

// File: rtl/boot_bus_translator.sv
// Turns one secure-boot controller payload request into an AHB-Lite INCR burst
// and returns done/err/read data to the controller.
module boot_bus_translator
  import mcse_bus_pkg::*;
#(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pTIMEOUT_CYCLES    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bootControl_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
  input  logic                          bootControl_bus_RW,
  output logic                          bootControl_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
  output logic                          bootControl_bus_err,
  output logic [pAHB_ADDR_WIDTH-1:0]    HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [pAHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic [pAHB_DATA_WIDTH-1:0]    HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);

  localparam int AW         = pAHB_ADDR_WIDTH;
  localparam int DW         = pAHB_DATA_WIDTH;
  localparam int PW         = pPAYLOAD_SIZE_BITS;
  localparam int BEATS      = PW / DW;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SHIFT = $clog2(DW / 8);
  localparam int ALIGN_BITS = $clog2(PW / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  btu_state_t state, state_next;

  logic [BEAT_W-1:0] addr_beat;
  logic [BEAT_W-1:0] data_beat;
  logic [AW-1:0]     start_addr;
  logic [PW-1:0]     wdata_q;
  logic [PW-1:0]     rd_data_q;
  logic              rw_q;
  logic              err_q;
  logic              data_phase;
  logic              misaligned;
  logic              wdt_timeout;
  logic              err_set;

  assign data_phase = (state == ST_BURST) || (state == ST_LAST);
  assign misaligned = |bootControl_bus_addr[ALIGN_BITS-1:0];
  assign err_set    = wdt_timeout || (HRESP && !HREADY);

  boot_bus_wdt #(
    .pTIMEOUT_CYCLES(pTIMEOUT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!data_phase || HREADY),
    .en     (data_phase && !HREADY),
    .timeout(wdt_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, beat counters and read capture; nothing moves while HREADY is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_beat  <= '0;
      data_beat  <= '0;
      start_addr <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bootControl_bus_go) begin
            start_addr <= bootControl_bus_addr;
            wdata_q    <= bootControl_bus_write;
            rw_q       <= bootControl_bus_RW;
            err_q      <= misaligned;
            addr_beat  <= '0;
            data_beat  <= '0;
            if (!bootControl_bus_RW) begin
              rd_data_q <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY && addr_beat != LAST_BEAT) begin
            addr_beat <= addr_beat + BEAT_W'(1);
          end
        end
        ST_BURST, ST_LAST: begin
          if (err_set) begin
            err_q <= 1'b1;
          end else if (HREADY) begin
            if (!rw_q) begin
              rd_data_q[data_beat*DW +: DW] <= HRDATA;
            end
            if (data_beat != LAST_BEAT) begin
              data_beat <= data_beat + BEAT_W'(1);
            end
            if (state == ST_BURST && addr_beat != LAST_BEAT) begin
              addr_beat <= addr_beat + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bootControl_bus_go) begin
          state_next = misaligned ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_next = (addr_beat == LAST_BEAT) ? ST_LAST : ST_BURST;
        end
      end
      ST_BURST, ST_LAST: begin
        if (wdt_timeout) begin
          state_next = ST_DONE;
        end else if (HRESP && !HREADY) begin
          state_next = ST_ERR1;
        end else if (HREADY) begin
          if (state == ST_LAST) begin
            state_next = ST_DONE;
          end else if (addr_beat == LAST_BEAT) begin
            state_next = ST_LAST;
          end
        end
      end
      ST_ERR1: begin
        if (HREADY) begin
          state_next = ST_ERR2;
        end
      end
      ST_ERR2: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs derive from registered state, so an async reset clears them at once
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HWDATA = '0;
    case (state)
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = rw_q;
      end
      ST_BURST: begin
        HTRANS = HTRANS_SEQ;
        HWRITE = rw_q;
      end
      default: ;
    endcase
    if (data_phase && rw_q) begin
      HWDATA = wdata_q[data_beat*DW +: DW];
    end
  end

  assign HADDR  = start_addr + (AW'(addr_beat) << BYTE_SHIFT);
  assign HSIZE  = hsize_for(DW);
  assign HBURST = HBURST_INCR;

  assign bootControl_bus_done   = (state == ST_DONE);
  assign bootControl_bus_err    = (state == ST_DONE) && err_q;
  assign bootControl_bus_rdData = rd_data_q;

endmodule

// File: tb/tb_boot_bus_translator.sv
// Directed checks of the boot bus translator: vector tables plus multi-cycle corner sequences.
module tb_boot_bus_translator;
  import mcse_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 128;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [PW-1:0] wdata = '0;
  logic          rw = 1'b0;
  logic          done;
  logic [PW-1:0] rd_data;
  logic          err;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata = '0;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  boot_bus_translator #(
    .pAHB_ADDR_WIDTH   (AW),
    .pAHB_DATA_WIDTH   (DW),
    .pPAYLOAD_SIZE_BITS(PW),
    .pTIMEOUT_CYCLES   (TO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bootControl_bus_go    (go),
    .bootControl_bus_addr  (addr),
    .bootControl_bus_write (wdata),
    .bootControl_bus_RW    (rw),
    .bootControl_bus_done  (done),
    .bootControl_bus_rdData(rd_data),
    .bootControl_bus_err   (err),
    .HADDR                 (haddr),
    .HTRANS                (htrans),
    .HWRITE                (hwrite),
    .HSIZE                 (hsize),
    .HBURST                (hburst),
    .HWDATA                (hwdata),
    .HRDATA                (hrdata),
    .HREADY                (hready),
    .HRESP                 (hresp)
  );

  typedef struct {
    logic          go;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [1:0]    exp_htrans;
    logic          chk_addr;
    logic [AW-1:0] exp_haddr;
    logic          exp_hwrite;
    logic          chk_wdata;
    logic [DW-1:0] exp_hwdata;
    logic          exp_done;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic g, input logic rdy, input logic rsp, input logic [DW-1:0] rd,
                              input logic [1:0] ht, input logic ca, input logic [AW-1:0] ea,
                              input logic ew, input logic cw, input logic [DW-1:0] ed,
                              input logic dn, input logic er);
    vec_t v;
    v.go = g; v.hready = rdy; v.hresp = rsp; v.hrdata = rd;
    v.exp_htrans = ht; v.chk_addr = ca; v.exp_haddr = ea; v.exp_hwrite = ew;
    v.chk_wdata = cw; v.exp_hwdata = ed; v.exp_done = dn; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  // One row per clock: inputs driven just after the edge, outputs sampled on the falling edge
  task automatic apply_stimulus(input string tag);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      go     = vecs[i].go;
      hready = vecs[i].hready;
      hresp  = vecs[i].hresp;
      hrdata = vecs[i].hrdata;
      @(negedge clk);
      check_output($sformatf("%s[%0d] htrans", tag, i), PW'(htrans), PW'(vecs[i].exp_htrans));
      check_output($sformatf("%s[%0d] done", tag, i), PW'(done), PW'(vecs[i].exp_done));
      check_output($sformatf("%s[%0d] err", tag, i), PW'(err), PW'(vecs[i].exp_err));
      if (vecs[i].chk_addr) begin
        check_output($sformatf("%s[%0d] haddr", tag, i), PW'(haddr), PW'(vecs[i].exp_haddr));
        check_output($sformatf("%s[%0d] hwrite", tag, i), PW'(hwrite), PW'(vecs[i].exp_hwrite));
      end
      if (vecs[i].chk_wdata) begin
        check_output($sformatf("%s[%0d] hwdata", tag, i), PW'(hwdata), PW'(vecs[i].exp_hwdata));
      end
    end
    vecs.delete();
    @(posedge clk);
    #1;
    go     = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
  endtask

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  int cyc;
  int done_cyc;
  int frozen_bad;
  int activity;
  logic got_done;
  logic done_err;
  logic [1:0] done_htrans;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset htrans", PW'(htrans), '0);
    check_output("reset haddr", PW'(haddr), '0);
    check_output("reset hwrite", PW'(hwrite), '0);
    check_output("reset hwdata", PW'(hwdata), '0);
    check_output("reset done", PW'(done), '0);
    check_output("reset err", PW'(err), '0);
    check_output("reset rdData", rd_data, '0);
    check_output("hsize", PW'(hsize), PW'(3'b010));
    check_output("hburst", PW'(hburst), PW'(3'b001));

    // Zero-wait write; a go during the DONE cycle must be dropped
    addr  = 32'h1000_0010;
    wdata = 128'h44444444_33333333_22222222_11111111;
    rw    = 1'b1;
    add(1, 1, 0, 0, TI, 0, 0,            0, 0, 0,            0, 0);
    add(0, 1, 0, 0, TN, 1, 32'h10000010, 1, 0, 0,            0, 0);
    add(0, 1, 0, 0, TS, 1, 32'h10000014, 1, 1, 32'h11111111, 0, 0);
    add(0, 1, 0, 0, TS, 1, 32'h10000018, 1, 1, 32'h22222222, 0, 0);
    add(0, 1, 0, 0, TS, 1, 32'h1000001C, 1, 1, 32'h33333333, 0, 0);
    add(0, 1, 0, 0, TI, 0, 0,            0, 1, 32'h44444444, 0, 0);
    add(1, 1, 0, 0, TI, 0, 0,            0, 0, 0,            1, 0);
    add(0, 1, 0, 0, TI, 0, 0,            0, 0, 0,            0, 0);
    add(0, 1, 0, 0, TI, 0, 0,            0, 0, 0,            0, 0);
    apply_stimulus("wr");

    // Read with two wait states on beat 2; junk HRDATA during waits must not be captured
    addr = 32'h20;
    rw   = 1'b0;
    add(1, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TN, 1, 32'h20, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hA0A0A0A0, TS, 1, 32'h24, 0, 1, 0, 0, 0);
    add(0, 1, 0, 32'hB1B1B1B1, TS, 1, 32'h28, 0, 1, 0, 0, 0);
    add(0, 0, 0, 32'hDEADBEEF, TS, 1, 32'h2C, 0, 1, 0, 0, 0);
    add(0, 0, 0, 32'hDEADBEEF, TS, 1, 32'h2C, 0, 1, 0, 0, 0);
    add(0, 1, 0, 32'hC2C2C2C2, TS, 1, 32'h2C, 0, 1, 0, 0, 0);
    add(0, 1, 0, 32'hD3D3D3D3, TI, 0, 0,     0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 1, 0);
    add(0, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 0, 0);
    apply_stimulus("rd");
    check_output("rd rdData", rd_data, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

    // Misaligned write: immediate error, no bus activity, read data untouched
    addr  = 32'h24;
    rw    = 1'b1;
    wdata = 128'h5;
    add(1, 1, 0, 0, TI, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, TI, 0, 0, 0, 1, 0, 1, 1);
    add(0, 1, 0, 0, TI, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, TI, 0, 0, 0, 1, 0, 0, 0);
    apply_stimulus("mis");
    check_output("mis rdData held", rd_data, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

    // Two-cycle ERROR response on beat 1 of a read
    addr = 32'h40;
    rw   = 1'b0;
    add(1, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TN, 1, 32'h40, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hE4E4E4E4, TS, 1, 32'h44, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'hBAD0BAD0, TS, 1, 32'h48, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'hBAD1BAD1, TI, 0, 0,     0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 1, 1);
    add(0, 1, 0, 32'h0,        TI, 0, 0,     0, 0, 0, 0, 0);
    apply_stimulus("hresp");
    check_output("hresp rdData partial", rd_data, 128'h00000000_00000000_00000000_E4E4E4E4);

    // HREADY stuck low in beat 0 data phase; a stray go mid-wait must be ignored
    addr  = 32'h80;
    wdata = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    rw    = 1'b1;
    @(posedge clk); #1 go = 1'b1; hready = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(posedge clk); #1 hready = 1'b0;
    cyc = 2; got_done = 1'b0; done_cyc = -1; frozen_bad = 0;
    done_err = 1'b0; done_htrans = 2'b11;
    while (!got_done && cyc < 2 + TO + 20) begin
      if (cyc == 10) begin
        addr = 32'h200;
        rw   = 1'b0;
        go   = 1'b1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        got_done    = 1'b1;
        done_cyc    = cyc;
        done_err    = err;
        done_htrans = htrans;
      end else if (htrans !== TS || haddr !== 32'h84 || hwdata !== 32'h0A0A0A0A) begin
        frozen_bad++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    go = 1'b0;
    hready = 1'b1;
    check_output("to done seen", PW'(got_done), PW'(1'b1));
    check_output("to done in window", PW'(done_cyc >= 2 + TO && done_cyc <= 2 + TO + 3), PW'(1'b1));
    check_output("to err", PW'(done_err), PW'(1'b1));
    check_output("to htrans at done", PW'(done_htrans), PW'(TI));
    check_output("to frozen during wait", PW'(frozen_bad), '0);
    activity = 0;
    repeat (6) begin
      @(negedge clk);
      if (htrans !== TI || done !== 1'b0) activity++;
    end
    check_output("to stray go not queued", PW'(activity), '0);

    // Reset in the middle of a burst
    addr  = 32'hC0;
    wdata = 128'h1;
    rw    = 1'b1;
    @(posedge clk); #1 go = 1'b1; hready = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst pre htrans", PW'(htrans), PW'(TS));
    @(posedge clk); #2 rst = 1'b1; #1;
    check_output("rst htrans", PW'(htrans), '0);
    check_output("rst haddr", PW'(haddr), '0);
    check_output("rst hwdata", PW'(hwdata), '0);
    check_output("rst done", PW'(done), '0);
    check_output("rst rdData", rd_data, '0);
    @(posedge clk); #1 rst = 1'b0;
    activity = 0;
    repeat (4) begin
      @(negedge clk);
      if (htrans !== TI || done !== 1'b0) activity++;
    end
    check_output("rst no done", PW'(activity), '0);

    addr = 32'h100;
    rw   = 1'b0;
    add(1, 1, 0, 32'h0,        TI, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TN, 1, 32'h100, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hF0F0F0F0, TS, 1, 32'h104, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hF1F1F1F1, TS, 1, 32'h108, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hF2F2F2F2, TS, 1, 32'h10C, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'hF3F3F3F3, TI, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,        TI, 0, 0,      0, 0, 0, 1, 0);
    apply_stimulus("post");
    check_output("post rdData", rd_data, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
